jtframe_i2s_tx: RTL and testbench

Serialises the frame's stereo PCM output (`snd_left`, `snd_right`, `sample`) into a standard Philips I2S stream for the external DAC.

- Sits directly downstream of the sound mixer on the target top level.
- Replaces the free-running 50 MHz `audio_top` with a block clocked by the system clock and gated by the frame's `sample` strobe.
- Double-buffers samples so a new word is only ever loaded on a frame boundary.

---
 rtl/jtframe_i2s_pkg.sv | 19 +
 rtl/jtframe_i2s_div.sv | 35 +++
 rtl/jtframe_i2s_tx.sv | 111 +++++++++++
 tb/tb_jtframe_i2s_tx.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_i2s_pkg.sv
// Shared helpers for the I2S transmitter: channel encoding, slot position
// and an elaboration-time parameter check.
package jtframe_i2s_pkg;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } chan_e;

  // Position inside the current channel slot; bitcnt is always < 2*slotw.
  function automatic int slot_pos(input int bitcnt, input int slotw);
    return (bitcnt >= slotw) ? bitcnt - slotw : bitcnt;
  endfunction

  function automatic bit params_ok(input int dw, input int slotw, input int bclk_half);
    return (slotw >= dw + 1) && (bclk_half >= 2);
  endfunction

endpackage

// File: rtl/jtframe_i2s_div.sv
// BCLK generator: divides clk by 2*BCLK_HALF and flags the cycle in which
// BCLK is about to fall.
module jtframe_i2s_div #(
  parameter int BCLK_HALF = 8
) (
  input  logic clk,
  input  logic rst_n,
  output logic o_bclk,
  output logic o_fall
);

  localparam int DIVW = $clog2(BCLK_HALF);

  logic [DIVW-1:0] r_div;
  logic            r_bclk;
  logic            w_tc;

  assign w_tc   = (r_div == DIVW'(BCLK_HALF - 1));
  assign o_fall = w_tc & r_bclk;
  assign o_bclk = r_bclk;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_div  <= '0;
      r_bclk <= 1'b0;
    end else if (w_tc) begin
      r_div  <= '0;
      r_bclk <= ~r_bclk;
    end else begin
      r_div  <= r_div + 1'b1;
    end
  end

endmodule

// File: rtl/jtframe_i2s_tx.sv
// Philips I2S serialiser for the frame's stereo PCM output. Samples are
// double-buffered: captured into hold on `sample`, moved to shift at frame start.
module jtframe_i2s_tx
  import jtframe_i2s_pkg::*;
#(
  parameter int BCLK_HALF  = 8,
  parameter int DW         = 16,
  parameter int SLOTW      = 32,
  parameter bit SIGNED_SND = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] snd_left,
  input  logic [DW-1:0] snd_right,
  input  logic          sample,
  output logic          i2s_bclk,
  output logic          i2s_lrclk,
  output logic          i2s_data,
  output logic          frame_start,
  output logic          overrun
);

  localparam int BCW = $clog2(2 * SLOTW);
  localparam int IW  = $clog2(DW);
  localparam logic [DW-1:0] MSB_FLIP = SIGNED_SND ? '0 : {1'b1, {(DW-1){1'b0}}};

  generate
    if (!params_ok(DW, SLOTW, BCLK_HALF)) begin : g_bad_params
      $error("jtframe_i2s_tx: needs SLOTW >= DW+1 and BCLK_HALF >= 2");
    end
  endgenerate

  logic           w_fall;
  logic           w_wrap;
  logic           w_load;
  logic [BCW-1:0] w_bitcnt_nxt;
  chan_e          w_ch;
  int             w_pos;
  logic [IW-1:0]  w_idx;
  logic [DW-1:0]  w_word;
  logic           w_bit;

  logic [BCW-1:0] r_bitcnt;
  logic [DW-1:0]  r_hold_l, r_hold_r;
  logic [DW-1:0]  r_shift_l, r_shift_r;
  logic           r_fresh;
  logic           r_lrclk, r_data, r_frame_start, r_overrun;

  jtframe_i2s_div #(.BCLK_HALF(BCLK_HALF)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .o_bclk (i2s_bclk),
    .o_fall (w_fall)
  );

  assign w_wrap       = (r_bitcnt == BCW'(2 * SLOTW - 1));
  assign w_load       = w_fall & w_wrap;
  assign w_bitcnt_nxt = w_wrap ? '0 : r_bitcnt + 1'b1;
  assign w_ch         = (w_bitcnt_nxt >= BCW'(SLOTW)) ? CH_RIGHT : CH_LEFT;

  // Bit that goes on the wire once bitcnt advances; p=0 is the I2S delay slot.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_bit  = 1'b0;
    w_pos  = slot_pos(int'(w_bitcnt_nxt), SLOTW);
    w_word = (w_ch == CH_RIGHT) ? r_shift_r : r_shift_l;
    w_idx  = IW'(DW - w_pos);
    if (w_pos >= 1 && w_pos <= DW) w_bit = w_word[w_idx];
  end

  // NOTE: hold and shift words are reset along with control state, so a frame
  // retransmitted right after reset is silence rather than stale data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bitcnt      <= '0;
      r_hold_l      <= '0;
      r_hold_r      <= '0;
      r_shift_l     <= '0;
      r_shift_r     <= '0;
      r_fresh       <= 1'b0;
      r_lrclk       <= 1'b0;
      r_data        <= 1'b0;
      r_frame_start <= 1'b0;
      r_overrun     <= 1'b0;
    end else begin
      if (w_fall) begin
        r_bitcnt <= w_bitcnt_nxt;
        r_lrclk  <= w_ch;
        r_data   <= w_bit;
      end
      // Load reads hold before a same-cycle capture overwrites it.
      if (w_load) begin
        r_shift_l <= r_hold_l;
        r_shift_r <= r_hold_r;
      end
      if (sample) begin
        r_hold_l <= snd_left ^ MSB_FLIP;
        r_hold_r <= snd_right ^ MSB_FLIP;
      end
      r_fresh       <= sample | (r_fresh & ~w_load);
      r_frame_start <= w_load;
      r_overrun     <= sample & r_fresh & ~w_load;
    end
  end

  assign i2s_lrclk   = r_lrclk;
  assign i2s_data    = r_data;
  assign frame_start = r_frame_start;
  assign overrun     = r_overrun;

endmodule

// File: tb/tb_jtframe_i2s_tx.sv
// Scoreboard bench for jtframe_i2s_tx: a signed and an offset-binary instance
// share stimulus; a monitor decodes both I2S streams and checks each frame.
module tb_jtframe_i2s_tx;

  localparam int DW    = 16;
  localparam int SLOTW = 32;
  localparam int FRAME = 1024;

  typedef struct packed {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample = 1'b0;
  logic [15:0] snd_l = '0;
  logic [15:0] snd_r = '0;
  logic        bclk[2], lr[2], dat[2], fs[2], ovr[2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int fs_cnt = 0;
  int ovr_cnt[2] = '{0, 0};

  pair_t exp_q0[$];
  pair_t exp_q1[$];

  jtframe_i2s_tx u_dut (
    .clk(clk), .rst_n(rst_n), .snd_left(snd_l), .snd_right(snd_r), .sample(sample),
    .i2s_bclk(bclk[0]), .i2s_lrclk(lr[0]), .i2s_data(dat[0]),
    .frame_start(fs[0]), .overrun(ovr[0])
  );

  jtframe_i2s_tx #(.SIGNED_SND(1'b0)) u_ob (
    .clk(clk), .rst_n(rst_n), .snd_left(snd_l), .snd_right(snd_r), .sample(sample),
    .i2s_bclk(bclk[1]), .i2s_lrclk(lr[1]), .i2s_data(dat[1]),
    .frame_start(fs[1]), .overrun(ovr[1])
  );

  always #5 clk = ~clk;

  // cyc == k right after the edge that ends cycle k (cycle 1 = first with rst_n=1)
  always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  // Holds sample high during cycle c so it is captured at the edge ending cycle c.
  task automatic send(input int c, input logic [15:0] l, input logic [15:0] r);
    if (cyc >= c) check("send_schedule", cyc, c - 1);
    while (cyc < c - 1) tick();
    snd_l  = l;
    snd_r  = r;
    sample = 1'b1;
    tick();
    sample = 1'b0;
  endtask

  task automatic push(input logic [15:0] l0, input logic [15:0] r0,
                      input logic [15:0] l1, input logic [15:0] r1);
    exp_q0.push_back('{l: l0, r: r0});
    exp_q1.push_back('{l: l1, r: r1});
  endtask

  // Monitor: edge timing on u_dut, I2S decode on both instances.
  initial begin
    logic  pb[2], plr[2], pad[2];
    int    pos[2];
    logic [15:0] sh[2], lw[2];
    int    last_rise, fall_cnt;
    bit    rise_pend, fall_pend, lr_pend;
    logic  lr_prev;
    pair_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pb = '{1'b0, 1'b0};
        plr = '{1'b1, 1'b1};
        pad = '{1'b0, 1'b0};
        pos = '{0, 0};
        sh = '{16'h0, 16'h0};
        lw = '{16'h0, 16'h0};
        last_rise = 0;
        fall_cnt = 0;
        rise_pend = 1'b1;
        fall_pend = 1'b1;
        lr_pend = 1'b1;
        lr_prev = 1'b0;
      end else begin
        if (bclk[0] && !pb[0]) begin
          if (rise_pend) begin
            check("first_bclk_rise", cyc, 8);
            rise_pend = 1'b0;
          end else begin
            check("bclk_period", cyc - last_rise, 16);
          end
          last_rise = cyc;
        end
        if (!bclk[0] && pb[0]) begin
          fall_cnt++;
          if (fall_pend) begin
            check("first_bclk_fall", cyc, 16);
            fall_pend = 1'b0;
          end
        end
        if (lr[0] && !lr_prev && lr_pend) begin
          check("lrclk_rise_falls", fall_cnt, 32);
          lr_pend = 1'b0;
        end
        lr_prev = lr[0];
        if (fs[0]) begin
          fs_cnt++;
          check("frame_start_phase", cyc % FRAME, 0);
        end
        if (ovr[0]) begin
          ovr_cnt[0]++;
          check("overrun_cycle", cyc, 1324);
        end
        if (ovr[1]) ovr_cnt[1]++;

        for (int i = 0; i < 2; i++) begin
          if (bclk[i] && !pb[i]) begin
            if (lr[i] != plr[i]) pos[i] = 0;
            else pos[i] = pos[i] + 1;
            plr[i] = lr[i];
            if (pos[i] >= 1 && pos[i] <= DW) sh[i] = {sh[i][14:0], dat[i]};
            else if (pos[i] == 0) pad[i] = dat[i];
            else pad[i] = pad[i] | dat[i];
            if (pos[i] == DW) begin
              if (!lr[i]) begin
                lw[i] = sh[i];
              end else if ((i == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                check(i == 0 ? "u0_unexpected_frame" : "ob_unexpected_frame", 1, 0);
              end else begin
                e = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                check(i == 0 ? "u0_left_word" : "ob_left_word", {16'h0, lw[i]}, {16'h0, e.l});
                check(i == 0 ? "u0_right_word" : "ob_right_word", {16'h0, sh[i]}, {16'h0, e.r});
              end
            end
            if (pos[i] == SLOTW - 1) check(i == 0 ? "u0_slot_pad" : "ob_slot_pad", pad[i], 0);
          end
          pb[i] = bclk[i];
        end
      end
    end
  end

  initial begin
    repeat (20000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;

    // Frame 0 goes out before any load: silence on both instances.
    push(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    send(500, 16'hA5C3, 16'h8001);
    push(16'hA5C3, 16'h8001, 16'h25C3, 16'h0001);
    // Two captures inside frame 1: overrun on the second, newest wins, then retransmit.
    send(1124, 16'h0001, 16'h1111);
    send(1324, 16'h0002, 16'h2222);
    push(16'h0002, 16'h2222, 16'h8002, 16'hA222);
    push(16'h0002, 16'h2222, 16'h8002, 16'hA222);
    send(3272, 16'h7777, 16'h0BAD);
    push(16'h7777, 16'h0BAD, 16'hF777, 16'h8BAD);
    // Capture in the load cycle of frame 4: load keeps the old word, no overrun.
    send(4096, 16'h1234, 16'h4321);
    push(16'h1234, 16'h4321, 16'h9234, 16'hC321);
    send(5300, 16'h0000, 16'hFFFF);
    push(16'h0000, 16'hFFFF, 16'h8000, 16'h7FFF);

    // Mid-frame reset in frame 7 while bitcnt = 40.
    wait_cyc(7 * FRAME + 40 * 16);
    check("pre_reset_lrclk", lr[0], 1);
    check("pre_reset_queue_empty", exp_q0.size() + exp_q1.size(), 0);
    rst_n = 1'b0;
    tick();
    check("reset_outputs_u0", {bclk[0], lr[0], dat[0], fs[0], ovr[0]}, 0);
    check("reset_outputs_ob", {bclk[1], lr[1], dat[1], fs[1], ovr[1]}, 0);
    rst_n = 1'b1;

    // Hold registers were cleared, so the next two frames are silence.
    push(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    push(16'h0000, 16'h0000, 16'h0000, 16'h0000);
    wait_cyc(2100);

    check("final_queue_empty", exp_q0.size() + exp_q1.size(), 0);
    check("frame_start_count", fs_cnt, 9);
    check("overrun_count_u0", ovr_cnt[0], 1);
    check("overrun_count_ob", ovr_cnt[1], 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
